// File: rtl/burst_mem_pkg.sv
// Shared types and line geometry for the burst memory model.
// Holds the controller state enum plus beat/line/offset widths.
// The geometry constants describe the default 4 x 64-bit line.
package burst_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_BURST,
        ST_WR_DATA,
        ST_WR_WAIT,
        ST_WR_RESP
    } state_t;

    localparam int BEAT_CNT_W  = 2;        // indexes beats 0..3 of a line
    localparam int LINE_BITS   = 64 * 4;   // DATA_WIDTH * BURST_LEN
    localparam int OFFSET_BITS = 5;        // 32-byte line

endpackage

// File: rtl/burst_mem_array.sv
// Line-organised storage: DEPTH x WIDTH single-port RAM.
// Ports: clk, we/addr/wdata write side, rdata combinational read of addr.
// No reset on contents; the controller registers whatever it reads.
module burst_mem_array
    import burst_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WIDTH = LINE_BITS
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/burst_mem_model.sv
// Cache-line burst memory on the bmem bus: 4-beat line reads/writes after LATENCY.
// Ports: clk, rst_n (sync, active-low), bmem_address/read/write/wdata in,
//        bmem_rdata/resp out (registered), error out (sticky protocol flag).
module burst_mem_model
    import burst_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = 4,
    parameter int LINE_DEPTH = 256,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] bmem_address,
    input  logic                  bmem_read,
    input  logic                  bmem_write,
    input  logic [DATA_WIDTH-1:0] bmem_wdata,
    output logic [DATA_WIDTH-1:0] bmem_rdata,
    output logic                  bmem_resp,
    output logic                  error
);

    localparam int IDX_W  = $clog2(LINE_DEPTH);
    localparam int LINE_W = DATA_WIDTH * BURST_LEN;
    localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t                  state;
    logic [BEAT_CNT_W-1:0]   beat_cnt;
    logic [LAT_W-1:0]        lat_cnt;
    logic [IDX_W-1:0]        line_idx;
    logic [LINE_W-1:0]       wr_line;
    logic [LINE_W-1:0]       commit_line;
    logic [LINE_W-1:0]       rd_line;
    logic [BEAT_CNT_W-1:0]   beat_inc;
    logic [DATA_WIDTH-1:0]   next_beat;
    logic [IDX_W-1:0]        req_idx;
    logic                    aligned;
    logic                    last_beat;
    logic                    lat_done;
    logic                    commit;
    logic                    err_now;
    logic                    unused_addr_bits;

    // Bits above the line index are don't-care: addresses wrap on the array size.
    assign unused_addr_bits = ^bmem_address[ADDR_WIDTH-1:OFFSET_BITS+IDX_W];

    always_comb begin
        req_idx   = bmem_address[OFFSET_BITS +: IDX_W];
        aligned   = (bmem_address[OFFSET_BITS-1:0] == '0);
        last_beat = (beat_cnt == BEAT_CNT_W'(BURST_LEN - 1));
        lat_done  = (lat_cnt == LAT_W'(LATENCY - 1));
        beat_inc  = beat_cnt + BEAT_CNT_W'(1);
        next_beat = rd_line[int'(beat_inc) * DATA_WIDTH +: DATA_WIDTH];

        // The last beat is still on the bus when the line is committed, so it is
        // merged straight into the array write rather than staged first.
        commit_line = wr_line;
        commit_line[(BURST_LEN-1)*DATA_WIDTH +: DATA_WIDTH] = bmem_wdata;
        commit = rst_n && (state == ST_WR_DATA) && bmem_write && last_beat;

        err_now = 1'b0;
        case (state)
            ST_IDLE:     err_now = (bmem_read && bmem_write) ||
                                   ((bmem_read || bmem_write) && !aligned);
            ST_RD_WAIT,
            ST_RD_BURST: err_now = bmem_write;
            ST_WR_DATA:  err_now = bmem_read || !bmem_write;
            ST_WR_WAIT,
            ST_WR_RESP:  err_now = bmem_read || bmem_write;
            default:     err_now = 1'b0;
        endcase
    end

    burst_mem_array #(
        .DEPTH (LINE_DEPTH),
        .WIDTH (LINE_W)
    ) u_array (
        .clk   (clk),
        .we    (commit),
        .addr  (line_idx),
        .wdata (commit_line),
        .rdata (rd_line)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            lat_cnt    <= '0;
            bmem_resp  <= 1'b0;
            bmem_rdata <= '0;
            error      <= 1'b0;
        end else begin
            error <= error | err_now;
            case (state)
                ST_IDLE: begin
                    if ((bmem_read != bmem_write) && aligned) begin
                        line_idx <= req_idx;
                        lat_cnt  <= '0;
                        if (bmem_read) begin
                            state <= ST_RD_WAIT;
                        end else begin
                            // The acceptance cycle already carries beat 0.
                            wr_line[DATA_WIDTH-1:0] <= bmem_wdata;
                            beat_cnt <= BEAT_CNT_W'(1);
                            state    <= ST_WR_DATA;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (lat_done) begin
                        bmem_resp  <= 1'b1;
                        bmem_rdata <= rd_line[DATA_WIDTH-1:0];
                        beat_cnt   <= '0;
                        state      <= ST_RD_BURST;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                ST_RD_BURST: begin
                    // beat_cnt tracks the beat currently on bmem_rdata.
                    if (last_beat) begin
                        bmem_resp  <= 1'b0;
                        bmem_rdata <= '0;
                        beat_cnt   <= '0;
                        state      <= ST_IDLE;
                    end else begin
                        bmem_rdata <= next_beat;
                        beat_cnt   <= beat_inc;
                    end
                end
                ST_WR_DATA: begin
                    if (!bmem_write) begin
                        beat_cnt <= '0;
                        state    <= ST_IDLE;
                    end else if (last_beat) begin
                        beat_cnt <= '0;
                        lat_cnt  <= '0;
                        state    <= ST_WR_WAIT;
                    end else begin
                        wr_line[int'(beat_cnt) * DATA_WIDTH +: DATA_WIDTH] <= bmem_wdata;
                        beat_cnt <= beat_inc;
                    end
                end
                ST_WR_WAIT: begin
                    if (lat_done) begin
                        bmem_resp <= 1'b1;
                        state     <= ST_WR_RESP;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                ST_WR_RESP: begin
                    bmem_resp <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_mem_model.sv
// Self-checking bench for burst_mem_model: per-cycle expected outputs from a
// transaction-level model (line memory + cycle-indexed expectation tables),
// plus a few literal checks on key cycles.
module tb_burst_mem_model;

    localparam int L    = 4;
    localparam int BL   = 4;
    localparam int NCYC = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] bmem_address = '0;
    logic        bmem_read = 1'b0;
    logic        bmem_write = 1'b0;
    logic [63:0] bmem_wdata = '0;
    logic [63:0] bmem_rdata;
    logic        bmem_resp;
    logic        error;

    burst_mem_model dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bmem_address (bmem_address),
        .bmem_read    (bmem_read),
        .bmem_write   (bmem_write),
        .bmem_wdata   (bmem_wdata),
        .bmem_rdata   (bmem_rdata),
        .bmem_resp    (bmem_resp),
        .error        (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state: line contents plus expected outputs for every cycle.
    logic [255:0] model_mem [256];
    bit           exp_resp  [NCYC];
    bit [63:0]    exp_rdata [NCYC];
    bit           exp_err   [NCYC];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc < NCYC) begin
            chk("resp",  64'(bmem_resp), 64'(exp_resp[cyc]));
            chk("rdata", bmem_rdata,     exp_rdata[cyc]);
            chk("error", 64'(error),     64'(exp_err[cyc]));
        end
    end

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 5) & 32'd255);
    endfunction

    function automatic void expect_read(input int t, input logic [31:0] a);
        for (int i = 0; i < BL; i++) begin
            exp_resp[t+1+L+i]  = 1'b1;
            exp_rdata[t+1+L+i] = model_mem[line_of(a)][64*i +: 64];
        end
    endfunction

    function automatic void set_err_from(input int t);
        for (int k = t; k < NCYC; k++) exp_err[k] = 1'b1;
    endfunction

    // Reset sampled at the end of cycle c: outputs are quiet from c+1 on.
    function automatic void clear_after(input int c);
        for (int k = c + 1; k < NCYC; k++) begin
            exp_resp[k]  = 1'b0;
            exp_rdata[k] = '0;
            exp_err[k]   = 1'b0;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_after(cyc);
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic do_read(input logic [31:0] a);
        int t;
        t = cyc;
        expect_read(t, a);
        bmem_address = a;
        bmem_read    = 1'b1;
        step();
        bmem_read = 1'b0;
        repeat (L + BL) step();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [255:0] line, input int n);
        int t;
        t = cyc;
        bmem_address = a;
        for (int i = 0; i < n; i++) begin
            bmem_write = 1'b1;
            bmem_wdata = line[64*i +: 64];
            step();
        end
        bmem_write = 1'b0;
        bmem_wdata = '0;
        if (n == BL) begin
            model_mem[line_of(a)] = line;
            exp_resp[t+BL+L] = 1'b1;
            repeat (L + 1) step();
        end else begin
            set_err_from(t + n + 1);
            repeat (2) step();
        end
    endtask

    logic [255:0] line_a, line_b, line_c;
    logic [63:0]  lits [4];
    int           t0;

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1);
    end

    initial begin
        line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        line_b = {64'hDDDD_0000_DDDD_0003, 64'hCCCC_0000_CCCC_0002,
                  64'hBBBB_0000_BBBB_0001, 64'hAAAA_0000_AAAA_0000};
        line_c = {64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000};
        lits[0] = 64'h1111_1111_1111_1111;
        lits[1] = 64'h2222_2222_2222_2222;
        lits[2] = 64'h3333_3333_3333_3333;
        lits[3] = 64'h4444_4444_4444_4444;
        for (int k = 0; k < NCYC; k++) begin
            exp_resp[k] = 1'b0; exp_rdata[k] = '0; exp_err[k] = 1'b0;
        end
        for (int k = 0; k < 256; k++) model_mem[k] = '0;

        step();
        step();
        rst_n = 1'b1;
        chk_en = 1'b1;
        step();

        // Basic write then read with literal beat checks.
        do_write(32'h0000_0040, line_a, BL);
        t0 = cyc;
        expect_read(t0, 32'h0000_0040);
        bmem_address = 32'h0000_0040;
        bmem_read    = 1'b1;
        step();
        bmem_read = 1'b0;
        repeat (L) step();
        for (int i = 0; i < BL; i++) begin
            @(negedge clk);
            chk("lit_rdata", bmem_rdata, lits[i]);
            chk("lit_resp", 64'(bmem_resp), 64'd1);
            step();
        end

        // Second pattern, then address wrap onto line 0.
        do_write(32'h0000_0060, line_c, BL);
        do_read(32'h0000_0060);
        do_write(32'h0000_2000, line_b, BL);
        do_read(32'h0000_0000);
        do_read(32'h0000_0040);

        // Truncated write keeps prior contents of line 0x40.
        do_write(32'h0000_0040, line_c, 2);
        do_read(32'h0000_0040);
        do_reset();

        // Misaligned read: dropped, error next cycle.
        t0 = cyc;
        set_err_from(t0 + 1);
        bmem_address = 32'h0000_0044;
        bmem_read    = 1'b1;
        step();
        bmem_read = 1'b0;
        @(negedge clk);
        chk("lit_misalign_err", 64'(error), 64'd1);
        step();
        step();
        do_reset();

        // Simultaneous read and write: dropped, controller stays idle.
        t0 = cyc;
        set_err_from(t0 + 1);
        bmem_address = 32'h0000_0040;
        bmem_read    = 1'b1;
        bmem_write   = 1'b1;
        step();
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        step();
        do_read(32'h0000_0060);
        do_reset();

        // Reset while beat 2 of a read is on the bus.
        t0 = cyc;
        expect_read(t0, 32'h0000_0040);
        bmem_address = 32'h0000_0040;
        bmem_read    = 1'b1;
        step();
        bmem_read = 1'b0;
        repeat (L + 2) step();
        rst_n = 1'b0;
        clear_after(cyc);
        step();
        @(negedge clk);
        chk("lit_rst_resp", 64'(bmem_resp), 64'd0);
        chk("lit_rst_rdata", bmem_rdata, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        do_read(32'h0000_0040);
        step();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/burst_mem_model.md
# burst_mem_model

Synthesizable cache-line burst memory that sits below the processor's cache hierarchy on the `bmem` bus. It services 256-bit line reads and writes as four 64-bit beats after a fixed access latency. It flags protocol violations on a sticky `error` output so the bench can stop on misuse. Storage is an internal line-organised RAM with no backing file.

## Interface
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 64: beat width.
- `BURST_LEN`, 4: beats per line. A line is 32 bytes.
- `LINE_DEPTH`, 256: number of lines stored. Must be a power of two.
- `LATENCY`, 4: idle cycles between request completion and the first response. Must be ≥ 1.

Ports:
- `clk`  in  1  clock. All logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `bmem_address`  in  ADDR_WIDTH  line byte address. Sampled at request acceptance.
- `bmem_read`  in  1  read request.
- `bmem_write`  in  1  write request and write-beat valid.
- `bmem_wdata`  in  DATA_WIDTH  write beat.
- `bmem_rdata`  out  DATA_WIDTH  read beat. Valid while `bmem_resp` is high during a read.
- `bmem_resp`  out  1  response strobe.
- `error`  out  1  sticky protocol-violation flag.

## Operation
- States: IDLE, RD_WAIT, RD_BURST, WR_DATA, WR_WAIT, WR_RESP.
- **Line index:** `bmem_address[$clog2(LINE_DEPTH)+4:5]`. Higher address bits are ignored, so addresses wrap modulo the memory size.
- **Beat order:** beat i = line bits [64i+63:64i], which is byte address addr+8i.
- **Read from IDLE:** `bmem_read`=1 and `bmem_write`=0 latches the address.
  - Go to RD_WAIT for LATENCY cycles.
  - Then RD_BURST for BURST_LEN cycles, driving `bmem_resp`=1 and beats 0..3 in order.
  - Return to IDLE.
  - `bmem_read` may stay high or drop after acceptance. Either is legal until the burst ends.
- **Write from IDLE:** `bmem_write`=1 marks the acceptance cycle, and that cycle carries beat 0.
  - `bmem_write` must stay high for BURST_LEN consecutive cycles carrying beats 0..3 (state WR_DATA).
  - The full line is committed to the array on the cycle of the last beat.
  - Then WR_WAIT for LATENCY cycles, then WR_RESP with a single-cycle `bmem_resp`=1, then IDLE.
- **Read-after-write:** a read issued after the write's `bmem_resp` returns the written data.
- **Error conditions.** Each sets `error`=1 permanently until reset:
  - `bmem_read` and `bmem_write` both high in IDLE. The request is dropped and the state stays IDLE.
  - `bmem_address[4:0]` ≠ 0 at acceptance. The request is dropped.
  - `bmem_write` drops before the last write beat. The write is abandoned without a commit, and the state returns to IDLE.
  - `bmem_write` is high in RD_WAIT, RD_BURST, WR_WAIT or WR_RESP, or `bmem_read` is high during any write state. The stray request is ignored and the current transaction continues.
- **Reset state:** `bmem_resp`=0, `bmem_rdata`=0, `error`=0, state IDLE, beat and latency counters cleared.
- Array contents are not reset. Contents read before any write are undefined.
- Reset asserted mid-transaction aborts it. A partially received write is not committed.

## Timing
- Request accepted in cycle T:
  - **Read:** `bmem_resp` is high in cycles T+1+LATENCY … T+LATENCY+BURST_LEN.
  - **Write:** beats arrive in T…T+3, and `bmem_resp` pulses at T+4+LATENCY.
- `bmem_rdata` and `bmem_resp` are registered outputs. `bmem_rdata` returns to 0 when `bmem_resp` is low.
- A new request is accepted in the first cycle after the state returns to IDLE. The earliest is the cycle after the last `bmem_resp`. Responses are therefore never back-to-back without a one-cycle gap.
- `error` is registered and asserts in the cycle after the offending input.

## Structure
- Package `burst_mem_pkg` holds:
  - the state enum;
  - `BEAT_CNT_W`, `LINE_BITS` (= DATA_WIDTH·BURST_LEN) and `OFFSET_BITS` (5).
- Sub-module `burst_mem_array`: single-port LINE_DEPTH×LINE_BITS RAM with synchronous write and combinational read. The read is registered by the controller's beat mux.
- Top-level module `burst_mem_model` contains the controller FSM, the latency and beat counters, the write assembly register and the error logic.

## Test plan
- **Basic write then read:** write line 0x0000_0040 with beats 0x11…, 0x22…, 0x33…, 0x44…, then read it back.
  - `bmem_resp` pulses once at T+8 for the write.
  - The read returns the four beats in order in cycles T+5…T+8, and `error` stays 0.
- **Address wrap:** write 0x0000_2000 with LINE_DEPTH=256, then read 0x0000_0000. The same data comes back.
- **Misaligned request:** read at 0x0000_0044. No `bmem_resp`, and `error`=1 the next cycle and stays 1.
- **Truncated write:** `bmem_write` is held for only 2 beats. `error`=1, no `bmem_resp`, and a later read of that line returns the prior contents.
- **Simultaneous read and write in IDLE:** both asserted together. `error`=1 and the state stays IDLE.
- **Mid-burst reset:** `rst_n`=0 during RD_BURST beat 2. The next cycle shows `bmem_resp`=0 and `bmem_rdata`=0, and a new read afterwards completes normally.
